// File: rtl/mult_secuencial8b_pkg.sv
// mult_secuencial8b_pkg
//   Shared constants and types for the sequential 8x8 shift-and-add multiplier.
//   WIDTH    : operand width (only 8 is supported; bound to Sum_instancia8b)
//   ITER_W   : width of the iteration counter (must hold 0..8)
//   TERM_CNT : number of add/shift iterations per product
//   state_e  : controller states IDLE / CALC / DONE
package mult_secuencial8b_pkg;

  localparam int WIDTH    = 8;
  localparam int ITER_W   = 4;
  localparam int TERM_CNT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_secuencial8b_adder.sv
// Sum_instancia8b
//   The team's combinational 8-bit ripple adder, used as the multiplier's
//   single arithmetic resource.
//   E_1, E_2 : 8-bit addends
//   Cu       : carry-in
//   S_F      : 8-bit sum
//   Cos      : carry-out
module Sum_instancia8b (
  input  logic [7:0] E_1,
  input  logic [7:0] E_2,
  input  logic       Cu,
  output logic [7:0] S_F,
  output logic       Cos
);

  assign {Cos, S_F} = 9'(E_1) + 9'(E_2) + 9'(Cu);

endmodule

// File: rtl/mult_secuencial8b.sv
// mult_secuencial8b
//   Sequential 8x8 unsigned shift-and-add multiplier. One add/shift per clock,
//   16-bit product loaded into P after 8 iterations, with a one-cycle done pulse.
//   Optional build macro MULT_ZERO_BYPASS_EN: a zero operand skips CALC and
//   goes straight to DONE with P=0.
//
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   start : request, sampled only in IDLE
//   A, B  : multiplicand / multiplier, captured when start is accepted
//   busy  : high while iterating (CALC)
//   done  : one-cycle pulse, P valid from this cycle on
//   P     : product, holds the last result until the next one is loaded
module mult_secuencial8b #(
  parameter int WIDTH  = mult_secuencial8b_pkg::WIDTH,
  parameter int ITER_W = mult_secuencial8b_pkg::ITER_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  import mult_secuencial8b_pkg::*;

  // The datapath is hard-wired to the 8-bit adder instance.
  if (WIDTH != 8) begin : g_width_check
    $error("mult_secuencial8b: only WIDTH=8 is supported");
  end

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    m_q, m_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]    q_q, q_d;
  logic                c_q, c_d;
  logic [ITER_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  p_q, p_d;

  logic [WIDTH-1:0]    sum;
  logic                cout;
  logic                zero_bypass;

  Sum_instancia8b u_adder (
    .E_1 (acc_q),
    .E_2 (m_q),
    .Cu  (1'b0),
    .S_F (sum),
    .Cos (cout)
  );

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_bypass = (A == '0) || (B == '0);
`else
  assign zero_bypass = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (zero_bypass) begin
            p_d     = '0;
            state_d = DONE;
          end else begin
            m_d     = A;
            q_d     = B;
            acc_d   = '0;
            c_d     = 1'b0;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        // The adder carry becomes the top bit of the shifted accumulator and
        // the bit shifted out of ACC enters the top of Q; after 8 steps
        // {ACC,Q} is the full product.
        if (q_q[0]) begin
          c_d   = cout;
          acc_d = {cout, sum[WIDTH-1:1]};
          q_d   = {sum[0], q_q[WIDTH-1:1]};
        end else begin
          c_d   = 1'b0;
          acc_d = {1'b0, acc_q[WIDTH-1:1]};
          q_d   = {acc_q[0], q_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ITER_W'(TERM_CNT - 1)) begin
          p_d     = {acc_d, q_d};
          state_d = DONE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; the reset is
    // sampled on the clock edge, not asynchronously.
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // Outputs decode directly from registers only.
  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign P    = p_q;

endmodule

// File: tb/tb_mult_secuencial8b.sv
// tb_mult_secuencial8b
//   Self-checking bench for mult_secuencial8b. Expected products come from
//   plain integer multiplication; expected busy/done timing comes from the
//   documented latency (done in cycle 9 after the accepting cycle, or cycle 1
//   when the zero bypass applies).
module tb_mult_secuencial8b;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        busy;
  logic        done;
  logic [15:0] P;

  int          total;
  int          bad;
  logic [15:0] prev_p;

  mult_secuencial8b dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int latency(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_ZERO_BYPASS_EN
    if (a == 8'h00 || b == 8'h00) return 1;
`endif
    return 9;
  endfunction

  // Called at a negedge with the DUT idle; that cycle is cycle 0.
  // Returns at the negedge of cycle lat+1, where the DUT is idle again.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    int          lat;
    logic [15:0] exp_p;
    lat   = latency(a, b);
    exp_p = 16'(a) * 16'(b);
    A     = a;
    B     = b;
    start = 1'b1;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      check("busy", 32'(busy), 32'(c < lat));
      check("done", 32'(done), 32'(c == lat));
      check("P", 32'(P), 32'((c >= lat) ? exp_p : prev_p));
      if (c == 1) begin
        start = 1'b0;
        A     = 8'($urandom);
        B     = 8'($urandom);
      end
    end
    prev_p = exp_p;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    prev_p = 16'h0000;
    rst_n  = 1'b0;
    start  = 1'b0;
    A      = 8'h00;
    B      = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_P", 32'(P), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operands, including the extreme case and the hold of P
    run_op(8'hFF, 8'hFF);
    run_op(8'd13, 8'd11);
    run_op(8'd2, 8'd2);
    run_op(8'h80, 8'h02);
    run_op(8'd13, 8'd11);
    run_op(8'h00, 8'h55);
    run_op(8'h55, 8'h00);
    run_op(8'h01, 8'hFF);

    // start held high: one done every 10 cycles, A/B changes while busy ignored
    A     = 8'd3;
    B     = 8'd5;
    start = 1'b1;
    for (int c = 1; c <= 29; c++) begin
      @(negedge clk);
      check("hold_done", 32'(done), 32'((c % 10) == 9));
      check("hold_busy", 32'(busy), 32'((c % 10) >= 1 && (c % 10) <= 8));
      if ((c % 10) == 9) check("hold_P", 32'(P), 32'd15);
      if ((c % 10) == 0) begin
        A = 8'd3;
        B = 8'd5;
      end else begin
        A = 8'($urandom);
        B = 8'($urandom);
      end
      if (c == 29) start = 1'b0;
    end
    @(negedge clk);
    check("hold_idle", 32'(busy), 32'd0);
    prev_p = 16'd15;

    // Reset during CALC: abandoned, no done, P cleared
    A     = 8'd7;
    B     = 8'd9;
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      check("pre_rst_busy", 32'(busy), 32'd1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_P", 32'(P), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("post_rst_done", 32'(done), 32'd0);
    end
    prev_p = 16'h0000;
    run_op(8'd7, 8'd9);

    // Randomized operands against plain multiplication, random idle gaps
    for (int n = 0; n < 40; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (n % 13 == 5) ra = 8'h00;
      run_op(ra, rb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_secuencial8b.md
Name: mult_secuencial8b

Overview:
Sequential 8x8 unsigned shift-and-add multiplier.
- Wraps the team's combinational 8-bit adder (Sum_instancia8b) as its only arithmetic resource: supplies the adder's operands and carry-in, and consumes its sum and carry-out each iteration.
- One add/shift per clock; the 16-bit product is ready after 8 iterations.
- Sits upstream of the ALU result mux / accumulator stage.

Parameters:
WIDTH, 8, operand width; only 8 is supported (bound to the 8-bit adder instance); wider values are a synthesis error.
ITER_W, 4, iteration counter width (counts 0..8).

Ports:
clk  input  1  single system clock; all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-low.
start  input  1  request; sampled only in IDLE.
A  input  8  multiplicand; captured when start is accepted.
B  input  8  multiplier; captured when start is accepted.
busy  output  1  high while in CALC.
done  output  1  one-cycle pulse; P is valid from this cycle on.
P  output  16  product A*B; holds last result until the next result is loaded.

Behaviour:
- Reset: rst_n low at a rising edge forces the following, regardless of state, including mid-CALC (operation abandoned, no done):
  - state=IDLE; busy=0; done=0; P=16'h0000.
  - Internal M, ACC, Q, C, cnt all cleared.
- States:
  - IDLE: start=1 -> M<=A, Q<=B, ACC<=0, cnt<=0; go to CALC. Otherwise stay.
  - CALC (busy=1): one iteration per cycle. Adder inputs: E_1=ACC, E_2=M, Cu=0; outputs {Cos,S_F}.
    - If Q[0]=1: ACC<={Cos,S_F[7:1]}, Q<={S_F[0],Q[7:1]}.
    - If Q[0]=0: ACC<={1'b0,ACC[7:1]}, Q<={ACC[0],Q[7:1]}.
    - cnt<=cnt+1. When cnt==7 (8th iteration), the same edge loads P<={next ACC,next Q}; go to DONE.
  - DONE: done=1 for exactly one cycle; busy=0; go to IDLE unconditionally.
- start handling: ignored in CALC and DONE; not queued. A/B changes outside the accepting edge have no effect.
- Latency: start sampled at end of cycle 0 -> busy in cycles 1..8 -> done=1 and P valid in cycle 9. Next accepted start is in cycle 10 at earliest (IDLE).
- Arithmetic: carry-out of the adder is the 9th bit of the shifted accumulator; no overflow is possible (8x8 fits 16).
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
Macro MULT_ZERO_BYPASS_EN.
- Defined: in IDLE, start=1 with A==0 or B==0 -> skip CALC; go directly to DONE with P<=0. done appears in cycle 1; busy stays 0.
- Undefined: zero operands take the full 8-iteration path (done in cycle 9, P=0).

Decomposition:
- Shared package/include:
  - WIDTH and ITER_W constants.
  - State encoding localparams: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - Iteration terminal count (8).
- Sub-module: one instance of the existing Sum_instancia8b as the datapath adder, no new adder.
- The controller FSM stays inline.

Test Plan:
- A=8'hFF, B=8'hFF, start one cycle -> busy cycles 1..8; done=1 in cycle 9 only; P=16'hFE01.
- A=13, B=11 -> P=16'h008F in cycle 9. Then A=8'h80, B=8'h02 -> P=16'h0100.
- start held high continuously, A=3, B=5 -> exactly one done per 10 cycles; each P=15; start in CALC/DONE ignored, with A/B changed during CALC not affecting the result.
- rst_n low in cycle 4 of CALC (A=7, B=9) -> next cycle: IDLE, busy=0, P=0, no done pulse; a new start then yields P=63.
- A=0, B=8'h55: without macro -> done in cycle 9, P=0. With MULT_ZERO_BYPASS_EN -> done in cycle 1, busy never high, P=0.
- Previous P=16'h008F, then new op A=2, B=2 -> P stays 8F through cycles 1..8 and changes to 16'h0004 in cycle 9.
